// File: rtl/apb4_mem_slave.sv
// APB4 memory-mapped slave.
// A register-array memory with byte-lane write strobes, a fixed number of wait
// states per transfer, an error response for misaligned or out-of-range
// addresses, and a saturating count of errored transfers.
module apb4_mem_slave #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int DEPTH       = 64,
  parameter int WAIT_CYCLES = 0,
  parameter int ERR_CNT_W   = 8
) (
  input  logic                    pclk,
  input  logic                    presetn,
  input  logic                    psel,
  input  logic                    penable,
  input  logic                    pwrite,
  input  logic [ADDR_WIDTH-1:0]   paddr,
  input  logic [DATA_WIDTH-1:0]   pwdata,
  input  logic [DATA_WIDTH/8-1:0] pstrb,
  output logic                    pready,
  output logic [DATA_WIDTH-1:0]   prdata,
  output logic                    pslverr,
  output logic [ERR_CNT_W-1:0]    err_cnt
);

  localparam int NBYTES = DATA_WIDTH / 8;
  localparam int LSB    = $clog2(NBYTES);
  localparam int IDX_W  = $clog2(DEPTH);

  // Address bits that must be zero: the byte offset inside a word, and every
  // bit above the highest word index.
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(NBYTES - 1);
  localparam logic [ADDR_WIDTH-1:0] RANGE_MASK = ~ADDR_WIDTH'(NBYTES * DEPTH - 1);

  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [3:0]             wcnt_q, wcnt_d;
  logic [ERR_CNT_W-1:0]   err_cnt_q, err_cnt_d;
  logic [DATA_WIDTH-1:0]  mem_q [DEPTH];

  logic             misaligned;
  logic             out_of_range;
  logic             err;
  logic [IDX_W-1:0] idx;
  logic             complete;
  logic             wr_en;

  // Address decode and transfer qualifiers for the current cycle.
  always_comb begin
    misaligned   = |(paddr & ALIGN_MASK);
    out_of_range = |(paddr & RANGE_MASK);
    err          = misaligned | out_of_range;
    idx          = paddr[LSB +: IDX_W];
    pready       = (state_q == ACCESS) && (wcnt_q == 4'd0);
    complete     = (state_q == ACCESS) && psel && pready;
    wr_en        = complete && pwrite && !err;
    pslverr      = pready && err;
    prdata       = (pready && !err) ? mem_q[idx] : '0;
    err_cnt      = err_cnt_q;
  end

  // Next-state logic for the transfer FSM, wait counter and error counter.
  always_comb begin
    state_d   = state_q;
    wcnt_d    = wcnt_q;
    err_cnt_d = err_cnt_q;
    case (state_q)
      IDLE: begin
        if (psel && !penable) state_d = SETUP;
      end
      SETUP: begin
        if (psel && penable) begin
          state_d = ACCESS;
          wcnt_d  = WAIT_LOAD;
        end else begin
          state_d = IDLE;
        end
      end
      ACCESS: begin
        if (!psel) begin
          // Master abandoned the transfer: nothing is written or counted.
          state_d = IDLE;
        end else if (pready) begin
          state_d = (psel && !penable) ? SETUP : IDLE;
          if (err && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + 1'b1;
        end else if (wcnt_q != 4'd0) begin
          wcnt_d = wcnt_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control state; asynchronous reset drops any transfer in flight.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q   <= IDLE;
      wcnt_q    <= 4'd0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      wcnt_q    <= wcnt_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  // Memory array: byte lanes written on the completing edge; contents survive reset.
  always_ff @(posedge pclk) begin
    if (wr_en) begin
      for (int i = 0; i < NBYTES; i++) begin
        if (pstrb[i]) mem_q[idx][8*i +: 8] <= pwdata[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_apb4_mem_slave.sv
// Testbench for apb4_mem_slave: two instances (two and zero wait states) driven
// by an APB master task and compared with a word-array reference model.
module tb_apb4_mem_slave;

  localparam int WAIT0 = 2;
  localparam int WAIT1 = 0;

  logic pclk = 1'b0;
  logic presetn;

  logic [1:0]       psel, penable, pwrite, pready, pslverr;
  logic [1:0][31:0] paddr, pwdata, prdata;
  logic [1:0][3:0]  pstrb;
  logic [1:0][7:0]  err_cnt;

  int n_chk  = 0;
  int n_pass = 0;

  logic [31:0] ref_mem [2][64];
  int          ref_cnt [2];

  always #5 pclk = ~pclk;

  apb4_mem_slave #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(64),
                   .WAIT_CYCLES(WAIT0), .ERR_CNT_W(8)) dut_w2 (
    .pclk(pclk), .presetn(presetn), .psel(psel[0]), .penable(penable[0]),
    .pwrite(pwrite[0]), .paddr(paddr[0]), .pwdata(pwdata[0]), .pstrb(pstrb[0]),
    .pready(pready[0]), .prdata(prdata[0]), .pslverr(pslverr[0]), .err_cnt(err_cnt[0])
  );

  apb4_mem_slave #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(64),
                   .WAIT_CYCLES(WAIT1), .ERR_CNT_W(8)) dut_w0 (
    .pclk(pclk), .presetn(presetn), .psel(psel[1]), .penable(penable[1]),
    .pwrite(pwrite[1]), .paddr(paddr[1]), .pwdata(pwdata[1]), .pstrb(pstrb[1]),
    .pready(pready[1]), .prdata(prdata[1]), .pslverr(pslverr[1]), .err_cnt(err_cnt[1])
  );

  // Master-visible access-phase length: one cycle while the slave registers
  // the setup, then WAIT+1 cycles in its access state.
  function automatic int exp_lat(input int s);
    return (s == 0) ? WAIT0 + 2 : WAIT1 + 2;
  endfunction

  function automatic bit addr_bad(input logic [31:0] a);
    return ((a % 4) != 0) || (a >= 32'd256);
  endfunction

  function automatic logic [31:0] rand_addr(input bit bad);
    logic [31:0] a;
    a = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
    if (bad) begin
      if ($urandom_range(0, 1) == 1) a[1:0] = 2'($urandom_range(1, 3));
      else a[8 + $urandom_range(0, 23)] = 1'b1;
    end
    return a;
  endfunction

  // Reference model of one completed transfer.
  task automatic ref_access(input int s, input bit wr, input logic [31:0] a,
                            input logic [31:0] d, input logic [3:0] st,
                            output logic [31:0] rd, output bit bad);
    bad = addr_bad(a);
    rd  = 32'h0;
    if (bad) begin
      if (ref_cnt[s] < 255) ref_cnt[s]++;
    end else if (wr) begin
      for (int i = 0; i < 4; i++)
        if (st[i]) ref_mem[s][a[7:2]][8*i +: 8] = d[8*i +: 8];
    end else begin
      rd = ref_mem[s][a[7:2]];
    end
  endtask

  // One complete APB transfer on bus s; lat = -1 if pready never came.
  task automatic apb_xfer(input int s, input bit wr, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] st,
                          output logic [31:0] rd, output bit serr, output int lat);
    @(negedge pclk);
    psel[s] = 1'b1; penable[s] = 1'b0; pwrite[s] = wr;
    paddr[s] = a; pwdata[s] = d; pstrb[s] = st;
    @(negedge pclk);
    penable[s] = 1'b1;
    rd = 32'h0; serr = 1'b0; lat = -1;
    for (int i = 1; i <= 40; i++) begin
      #1;
      if (pready[s] === 1'b1) begin
        rd = prdata[s]; serr = pslverr[s]; lat = i;
        break;
      end
      @(negedge pclk);
    end
    @(posedge pclk);
    #1;
    psel[s] = 1'b0; penable[s] = 1'b0;
  endtask

  task automatic test_reset();
    presetn = 1'b0;
    psel = '0; penable = '0; pwrite = '0; paddr = '0; pwdata = '0; pstrb = '0;
    ref_cnt[0] = 0; ref_cnt[1] = 0;
    repeat (3) @(negedge pclk);
    #1;
    for (int s = 0; s < 2; s++) begin
      n_chk++;
      if (pready[s] !== 1'b0 || pslverr[s] !== 1'b0 || prdata[s] !== 32'h0 || err_cnt[s] !== 8'h0)
        $display("FAIL reset_outputs[%0d]: pready=%b pslverr=%b prdata=%h err_cnt=%0d, need all zero",
                 s, pready[s], pslverr[s], prdata[s], err_cnt[s]);
      else n_pass++;
    end
    @(negedge pclk);
    presetn = 1'b1;
  endtask

  task automatic test_init();
    logic [31:0] rd, er, d; bit serr, eb; int lat;
    for (int s = 0; s < 2; s++) begin
      for (int w = 0; w < 64; w++) begin
        d = $urandom;
        apb_xfer(s, 1'b1, 32'(w * 4), d, 4'hF, rd, serr, lat);
        ref_access(s, 1'b1, 32'(w * 4), d, 4'hF, er, eb);
        n_chk++;
        if (serr !== 1'b0 || lat != exp_lat(s))
          $display("FAIL init_write[%0d][%0d]: pslverr=%b lat=%0d, need 0 and %0d", s, w, serr, lat, exp_lat(s));
        else n_pass++;
      end
    end
  endtask

  task automatic test_write_read();
    logic [31:0] rd, er; bit serr, eb; int lat;
    apb_xfer(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd, serr, lat);
    ref_access(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, er, eb);
    n_chk++;
    if (lat != 4 || serr !== 1'b0)
      $display("FAIL wr_latency: lat=%0d pslverr=%b, need 4 and 0", lat, serr);
    else n_pass++;
    apb_xfer(0, 1'b0, 32'h10, 32'h0, 4'h0, rd, serr, lat);
    ref_access(0, 1'b0, 32'h10, 32'h0, 4'h0, er, eb);
    n_chk++;
    if (lat != 4 || serr !== 1'b0 || rd !== 32'hDEADBEEF || rd !== er)
      $display("FAIL rd_deadbeef: lat=%0d pslverr=%b prdata=%h, need 4 0 %h", lat, serr, rd, er);
    else n_pass++;
  endtask

  task automatic test_strobe();
    logic [31:0] rd, er; bit serr, eb; int lat;
    apb_xfer(0, 1'b1, 32'h20, 32'h11223344, 4'hF, rd, serr, lat);
    ref_access(0, 1'b1, 32'h20, 32'h11223344, 4'hF, er, eb);
    apb_xfer(0, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, rd, serr, lat);
    ref_access(0, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, er, eb);
    apb_xfer(0, 1'b0, 32'h20, 32'h0, 4'hF, rd, serr, lat);
    ref_access(0, 1'b0, 32'h20, 32'h0, 4'hF, er, eb);
    n_chk++;
    if (rd !== 32'h11BB33DD || serr !== 1'b0)
      $display("FAIL strobe_merge: prdata=%h pslverr=%b, need 11bb33dd 0", rd, serr);
    else n_pass++;
  endtask

  task automatic test_errors();
    logic [31:0] rd, er; bit serr, eb; int lat;
    apb_xfer(0, 1'b0, 32'h100, 32'h0, 4'h0, rd, serr, lat);
    ref_access(0, 1'b0, 32'h100, 32'h0, 4'h0, er, eb);
    n_chk++;
    if (serr !== 1'b1 || rd !== 32'h0 || lat != 4)
      $display("FAIL err_oor_read: pslverr=%b prdata=%h lat=%0d, need 1 0 4", serr, rd, lat);
    else n_pass++;
    apb_xfer(0, 1'b1, 32'h06, 32'hCAFEF00D, 4'hF, rd, serr, lat);
    ref_access(0, 1'b1, 32'h06, 32'hCAFEF00D, 4'hF, er, eb);
    n_chk++;
    if (serr !== 1'b1 || lat != 4)
      $display("FAIL err_misaligned_write: pslverr=%b lat=%0d, need 1 4", serr, lat);
    else n_pass++;
    #1;
    n_chk++;
    if (err_cnt[0] !== 8'd2 || ref_cnt[0] != 2)
      $display("FAIL err_cnt_two: err_cnt=%0d, need 2", err_cnt[0]);
    else n_pass++;
    apb_xfer(0, 1'b0, 32'h04, 32'h0, 4'h0, rd, serr, lat);
    ref_access(0, 1'b0, 32'h04, 32'h0, 4'h0, er, eb);
    n_chk++;
    if (rd !== er || serr !== 1'b0)
      $display("FAIL err_mem_unchanged: prdata=%h pslverr=%b, need %h 0", rd, serr, er);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd, er; bit serr, eb; int lat;
    @(negedge pclk);
    psel[0] = 1'b1; penable[0] = 1'b0; pwrite[0] = 1'b1;
    paddr[0] = 32'h30; pwdata[0] = 32'h55; pstrb[0] = 4'hF;
    @(negedge pclk);
    penable[0] = 1'b1;
    repeat (2) @(negedge pclk);
    presetn = 1'b0;
    ref_cnt[0] = 0; ref_cnt[1] = 0;
    #1;
    n_chk++;
    if (pready[0] !== 1'b0 || pslverr[0] !== 1'b0 || prdata[0] !== 32'h0 || err_cnt[0] !== 8'h0)
      $display("FAIL reset_mid_outputs: pready=%b pslverr=%b prdata=%h err_cnt=%0d, need all zero",
               pready[0], pslverr[0], prdata[0], err_cnt[0]);
    else n_pass++;
    psel[0] = 1'b0; penable[0] = 1'b0;
    repeat (2) @(negedge pclk);
    presetn = 1'b1;
    apb_xfer(0, 1'b0, 32'h30, 32'h0, 4'h0, rd, serr, lat);
    ref_access(0, 1'b0, 32'h30, 32'h0, 4'h0, er, eb);
    n_chk++;
    if (rd !== er || lat != 4)
      $display("FAIL reset_mid_old_value: prdata=%h lat=%0d, need %h 4", rd, lat, er);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd, er, d; bit serr, eb; int lat;
    for (int k = 0; k < 4; k++) begin
      d = $urandom;
      apb_xfer(1, 1'b1, 32'(k * 4), d, 4'hF, rd, serr, lat);
      ref_access(1, 1'b1, 32'(k * 4), d, 4'hF, er, eb);
      n_chk++;
      if (lat != 2 || serr !== 1'b0)
        $display("FAIL b2b_write[%0d]: lat=%0d pslverr=%b, need 2 0", k, lat, serr);
      else n_pass++;
    end
    for (int k = 0; k < 4; k++) begin
      apb_xfer(1, 1'b0, 32'(k * 4), 32'h0, 4'h0, rd, serr, lat);
      ref_access(1, 1'b0, 32'(k * 4), 32'h0, 4'h0, er, eb);
      n_chk++;
      if (lat != 2 || rd !== er)
        $display("FAIL b2b_read[%0d]: lat=%0d prdata=%h, need 2 %h", k, lat, rd, er);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    logic [31:0] rd, er, a, d; logic [3:0] st; bit serr, eb, wr; int lat, s;
    for (int k = 0; k < 80; k++) begin
      s  = $urandom_range(0, 1);
      wr = 1'($urandom_range(0, 1));
      a  = rand_addr($urandom_range(0, 3) == 0);
      d  = $urandom;
      st = 4'($urandom_range(0, 15));
      apb_xfer(s, wr, a, d, st, rd, serr, lat);
      ref_access(s, wr, a, d, st, er, eb);
      #1;
      n_chk++;
      if (lat != exp_lat(s) || serr !== eb || (!wr && rd !== er) || err_cnt[s] !== 8'(ref_cnt[s]))
        $display("FAIL random[%0d] s=%0d wr=%b a=%h: lat=%0d pslverr=%b prdata=%h err_cnt=%0d, need %0d %b %h %0d",
                 k, s, wr, a, lat, serr, rd, err_cnt[s], exp_lat(s), eb, er, ref_cnt[s]);
      else n_pass++;
    end
  endtask

  task automatic test_abort();
    logic [31:0] rd, er; bit serr, eb; int lat, seen;
    seen = 0;
    @(negedge pclk);
    psel[0] = 1'b1; penable[0] = 1'b0; pwrite[0] = 1'b1;
    paddr[0] = 32'h40; pwdata[0] = ~ref_mem[0][16]; pstrb[0] = 4'hF;
    @(negedge pclk);
    penable[0] = 1'b1;
    #1; if (pready[0] === 1'b1) seen++;
    @(negedge pclk);
    #1; if (pready[0] === 1'b1) seen++;
    psel[0] = 1'b0; penable[0] = 1'b0;
    repeat (4) begin
      @(negedge pclk); #1; if (pready[0] === 1'b1) seen++;
    end
    n_chk++;
    if (seen != 0) $display("FAIL abort_no_pready: pready seen %0d times, need 0", seen);
    else n_pass++;
    psel[0] = 1'b1; penable[0] = 1'b1; pwrite[0] = 1'b0;
    repeat (4) begin
      @(negedge pclk); #1; if (pready[0] === 1'b1) seen++;
    end
    psel[0] = 1'b0; penable[0] = 1'b0;
    n_chk++;
    if (seen != 0) $display("FAIL idle_access_ignored: pready seen %0d times, need 0", seen);
    else n_pass++;
    apb_xfer(0, 1'b0, 32'h40, 32'h0, 4'h0, rd, serr, lat);
    ref_access(0, 1'b0, 32'h40, 32'h0, 4'h0, er, eb);
    n_chk++;
    if (rd !== er || lat != 4)
      $display("FAIL abort_no_write: prdata=%h lat=%0d, need %h 4", rd, lat, er);
    else n_pass++;
  endtask

  task automatic test_saturation();
    logic [31:0] rd, er, a; bit serr, eb; int lat, nerr;
    nerr = 0;
    for (int k = 0; k < 300; k++) begin
      a = rand_addr(1'b1);
      apb_xfer(1, k[0], a, $urandom, 4'hF, rd, serr, lat);
      ref_access(1, k[0], a, 32'h0, 4'hF, er, eb);
      if (serr === 1'b1) nerr++;
    end
    #1;
    n_chk++;
    if (nerr != 300) $display("FAIL sat_pslverr: errors flagged %0d, need 300", nerr);
    else n_pass++;
    n_chk++;
    if (err_cnt[1] !== 8'd255 || ref_cnt[1] != 255)
      $display("FAIL sat_err_cnt: err_cnt=%0d, need 255", err_cnt[1]);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_init();
    test_write_read();
    test_strobe();
    test_errors();
    test_reset_mid();
    test_back_to_back();
    test_random();
    test_abort();
    test_saturation();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
